// File: rtl/stepper_cmd_sequencer.sv
// stepper_cmd_sequencer: assembles 4-byte UART move frames, divides the rpm into a
// half-step period and drives step/direction outputs with done/abort pulses.
module stepper_cmd_sequencer #(
    parameter int unsigned STEP_DIV_NUM = 1800000,
    parameter int unsigned BYTE_TIMEOUT = 100000
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Step,
    output logic        o_Pin1,
    output logic        o_Pin2,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Abort,
    output logic [15:0] o_Steps_Left
);

    localparam logic [20:0]   DVD     = 21'(STEP_DIV_NUM);
    localparam int            TW      = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_END = TW'(BYTE_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RUN} state_t;

    state_t        r_State, w_Next;
    logic [1:0]    r_Idx;
    logic [23:0]   r_Lo;
    logic [TW-1:0] r_Tmo;
    logic          r_Step, r_Pin1, r_Pin2, r_Done, r_Abort;
    logic [15:0]   r_Left;
    logic [14:0]   r_Div, r_Rem;
    logic [20:0]   r_Quo, r_Hp;
    logic [4:0]    r_Cnt;

    logic [31:0]   w_Word;
    logic          w_Frame, w_Dir;
    logic [14:0]   w_Rpm;
    logic [15:0]   w_Steps, w_Trial;
    logic          w_Ge, w_Hp_End, w_Accept, w_Zero, w_Stop, w_Toggle, w_Last;

    // B3 is taken straight from the bus so the frame is usable on its own strobe
    assign w_Word   = {i_Rx_Byte, r_Lo};
    assign w_Frame  = i_Rx_DV && r_Idx == 2'd3;
    assign w_Dir    = w_Word[31];
    assign w_Rpm    = w_Word[30:16];
    assign w_Steps  = w_Word[15:0];

    // r_Quo starts as the dividend and shifts quotient bits in from the right
    assign w_Trial  = {r_Rem, r_Quo[20]};
    assign w_Ge     = w_Trial >= {1'b0, r_Div};
    assign w_Hp_End = ({1'b0, r_Hp} + 22'd1) >= {1'b0, r_Quo};

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Idx <= '0;
            r_Lo  <= '0;
            r_Tmo <= '0;
        end else if (i_Rx_DV) begin
            r_Idx <= r_Idx + 2'd1;
            r_Lo  <= {i_Rx_Byte, r_Lo[23:8]};
            r_Tmo <= '0;
        end else if (r_Idx != 2'd0) begin
            r_Idx <= r_Tmo == TMO_END ? 2'd0 : r_Idx;
            r_Tmo <= r_Tmo == TMO_END ? '0 : r_Tmo + 1'b1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) r_State <= S_IDLE;
        else          r_State <= w_Next;
    end

    always_comb begin
        w_Next = r_State;
        case (r_State)
            S_IDLE:  w_Next = w_Accept ? S_DIV : S_IDLE;
            S_DIV:   w_Next = w_Stop ? S_IDLE : (r_Cnt == 5'd20 ? S_RUN : S_DIV);
            S_RUN:   w_Next = (w_Stop || w_Last) ? S_IDLE : S_RUN;
            default: w_Next = S_IDLE;
        endcase
    end

    always_comb begin
        o_Busy   = r_State != S_IDLE;
        w_Accept = r_State == S_IDLE && w_Frame && w_Rpm != '0 && w_Steps != '0;
        w_Zero   = r_State == S_IDLE && w_Frame && w_Rpm != '0 && w_Steps == '0;
        w_Stop   = r_State != S_IDLE && w_Frame && w_Rpm == '0;
        w_Toggle = r_State == S_RUN && w_Hp_End;
        w_Last   = w_Toggle && r_Step && r_Left == 16'd1;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Step  <= 1'b0;
            r_Pin1  <= 1'b0;
            r_Pin2  <= 1'b0;
            r_Done  <= 1'b0;
            r_Abort <= 1'b0;
            r_Left  <= '0;
            r_Div   <= '0;
            r_Rem   <= '0;
            r_Quo   <= '0;
            r_Cnt   <= '0;
            r_Hp    <= '0;
        end else begin
            r_Done  <= w_Zero || (w_Last && !w_Stop);
            r_Abort <= w_Stop;
            if (w_Accept) begin
                r_Pin1 <= w_Dir;
                r_Pin2 <= !w_Dir;
                r_Left <= w_Steps;
                r_Div  <= w_Rpm;
                r_Rem  <= '0;
                r_Quo  <= DVD;
                r_Cnt  <= '0;
            end
            if (w_Stop) begin
                r_Step <= 1'b0;
                r_Left <= '0;
            end else if (r_State == S_DIV) begin
                r_Rem <= w_Ge ? 15'(w_Trial - {1'b0, r_Div}) : w_Trial[14:0];
                r_Quo <= {r_Quo[19:0], w_Ge};
                r_Cnt <= r_Cnt + 5'd1;
                if (r_Cnt == 5'd20) begin
                    r_Step <= 1'b1;
                    r_Hp   <= '0;
                end
            end else if (r_State == S_RUN) begin
                r_Hp <= w_Toggle ? '0 : r_Hp + 21'd1;
                if (w_Toggle) begin
                    r_Step <= !r_Step;
                    r_Left <= r_Step ? r_Left - 16'd1 : r_Left;
                end
            end
        end
    end

    assign o_Step       = r_Step;
    assign o_Pin1       = r_Pin1;
    assign o_Pin2       = r_Pin2;
    assign o_Done       = r_Done;
    assign o_Abort      = r_Abort;
    assign o_Steps_Left = r_Left;

endmodule

// File: tb/tb_stepper_cmd_sequencer.sv
// tb_stepper_cmd_sequencer: scheduled byte stimulus checked every cycle against a
// timeline model of frames, half-step periods, done/abort pulses and timeouts.
module tb_stepper_cmd_sequencer;

    localparam int unsigned DIV = 1800000;
    localparam int unsigned BT  = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  rx = 8'h00;
    logic        o_Step, o_Pin1, o_Pin2, o_Busy, o_Done, o_Abort;
    logic [15:0] o_Steps_Left;
    logic [21:0] obs;

    stepper_cmd_sequencer #(.STEP_DIV_NUM(DIV), .BYTE_TIMEOUT(BT)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(rx),
        .o_Step(o_Step), .o_Pin1(o_Pin1), .o_Pin2(o_Pin2), .o_Busy(o_Busy),
        .o_Done(o_Done), .o_Abort(o_Abort), .o_Steps_Left(o_Steps_Left)
    );

    always #5 clk = ~clk;
    assign obs = {o_Step, o_Pin1, o_Pin2, o_Busy, o_Done, o_Abort, o_Steps_Left};

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fb[$];
    logic [8:0] sq[$];
    int idle;
    bit mv_on, e_pin1, e_pin2, e_done, e_abort;
    int mv_n, mv_s, mv_q;

    // Expected outputs from the move timeline: n = edges since the accepting B3 strobe
    function automatic logic [21:0] exp_vec();
        logic st;
        int fl;
        st = 1'b0;
        fl = 0;
        if (mv_on) begin
            st = mv_n >= 21 && ((mv_n - 21) / mv_q) % 2 == 0;
            fl = mv_n < 21 + mv_q ? 0 : (mv_n - 21 - mv_q) / (2 * mv_q) + 1;
        end
        return {st, e_pin1, e_pin2, mv_on, e_done, e_abort, mv_on ? 16'(mv_s - fl) : 16'd0};
    endfunction

    task automatic model_reset();
        mv_on = 0; fb.delete(); idle = 0;
        e_pin1 = 0; e_pin2 = 0; e_done = 0; e_abort = 0;
    endtask

    task automatic tick(input logic [8:0] e);
        logic [31:0] w;
        bit was_on, fr;
        dv = e[8];
        rx = e[7:0];
        @(posedge clk);
        #1;
        dv = 1'b0;
        e_done = 0; e_abort = 0; fr = 0; w = '0;
        if (e[8]) begin
            fb.push_back(e[7:0]);
            idle = 0;
            if (fb.size() == 4) begin
                w = {fb[3], fb[2], fb[1], fb[0]};
                fr = 1;
                fb.delete();
            end
        end else if (fb.size() > 0) begin
            idle++;
            if (idle == BT) fb.delete();
        end
        was_on = mv_on;
        if (mv_on) begin
            mv_n++;
            if (mv_n == 21 + (2 * mv_s - 1) * mv_q) begin mv_on = 0; e_done = 1; end
        end
        if (fr && was_on && w[30:16] == 15'd0) begin
            mv_on = 0; e_done = 0; e_abort = 1;
        end else if (fr && !was_on && w[30:16] != 15'd0) begin
            if (w[15:0] == 16'd0) e_done = 1;
            else begin
                mv_on = 1; mv_n = 0;
                mv_s = 32'(w[15:0]);
                mv_q = int'(DIV / 32'(w[30:16]));
                e_pin1 = w[31]; e_pin2 = !w[31];
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        sq.push_back({1'b1, b});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sq.push_back(9'h000);
    endtask

    task automatic push_frame(input logic [31:0] w);
        for (int i = 0; i < 4; i++) sq.push_back({1'b1, w[8*i +: 8]});
    endtask

    task automatic test_reset();
        #23;
        n_cmp++;
        if (obs !== 22'h0) begin n_bad++; $display("FAIL reset_hold: got %h want 000000", obs); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        push_idle(6);
        while (sq.size() > 0) begin
            tick(sq.pop_front());
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_direction();
        for (int d = 0; d < 2; d++) begin
            int i, rise, hi, dn;
            i = 0; rise = -1; hi = 0; dn = 0;
            push_frame(d == 0 ? 32'hC6500003 : 32'h46500003);
            push_idle(21 + 600 + 10);
            while (sq.size() > 0) begin
                tick(sq.pop_front());
                n_cmp++;
                if (obs !== exp_vec()) begin n_bad++; $display("FAIL dir%0d_wave: got %h want %h", 1 - d, obs, exp_vec()); end
                if (o_Step && rise < 0) rise = i - 3;
                hi += int'(o_Step);
                dn += int'(o_Done);
                i++;
            end
            n_cmp++;
            if (rise !== 21) begin n_bad++; $display("FAIL dir%0d_rise: got T+%0d want T+22", 1 - d, rise + 1); end
            n_cmp++;
            if (hi !== 300) begin n_bad++; $display("FAIL dir%0d_high: got %0d want 300", 1 - d, hi); end
            n_cmp++;
            if (dn !== 1) begin n_bad++; $display("FAIL dir%0d_done: got %0d want 1", 1 - d, dn); end
            n_cmp++;
            if ({o_Pin1, o_Pin2, o_Busy} !== {d == 0, d != 0, 1'b0}) begin
                n_bad++; $display("FAIL dir%0d_pins: got %b want %b", 1 - d, {o_Pin1, o_Pin2, o_Busy}, {d == 0, d != 0, 1'b0});
            end
        end
    endtask

    task automatic test_timeout();
        int falls, dn;
        bit ps;
        falls = 0; dn = 0; ps = 0;
        push_byte(8'h03); push_byte(8'h00);
        push_idle(BT);
        push_frame(32'h46500005);
        push_idle(21 + 900 + 10);
        for (int i = 0; i < 4; i++) begin
            push_byte(i == 0 ? 8'h02 : i == 1 ? 8'h00 : i == 2 ? 8'h50 : 8'h46);
            push_idle(i < 3 ? BT - 1 : 21 + 300 + 10);
        end
        while (sq.size() > 0) begin
            tick(sq.pop_front());
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL timeout_wave: got %h want %h", obs, exp_vec()); end
            falls += int'(ps && !o_Step);
            ps = o_Step;
            dn += int'(o_Done);
        end
        n_cmp++;
        if (falls !== 7) begin n_bad++; $display("FAIL timeout_steps: got %0d want 7", falls); end
        n_cmp++;
        if (dn !== 2) begin n_bad++; $display("FAIL timeout_done: got %0d want 2", dn); end
    endtask

    task automatic test_abort();
        int ab, dn;
        ab = 0; dn = 0;
        push_frame(32'h465000FF);
        push_idle(21 + 300 + 5);
        push_frame(32'h00000000);
        push_idle(50);
        push_frame(32'h46500001);
        push_idle(21 + 100 - 4);
        push_frame(32'h00000000);
        push_idle(10);
        while (sq.size() > 0) begin
            tick(sq.pop_front());
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL abort_wave: got %h want %h", obs, exp_vec()); end
            ab += int'(o_Abort);
            dn += int'(o_Done);
        end
        n_cmp++;
        if (ab !== 2) begin n_bad++; $display("FAIL abort_count: got %0d want 2", ab); end
        n_cmp++;
        if (dn !== 0) begin n_bad++; $display("FAIL abort_nodone: got %0d want 0", dn); end
        n_cmp++;
        if ({o_Step, o_Steps_Left} !== 17'h0) begin n_bad++; $display("FAIL abort_final: got %h want 00000", {o_Step, o_Steps_Left}); end
    endtask

    task automatic test_ignored();
        int dn, hi;
        dn = 0; hi = 0;
        push_frame(32'h46500000);
        push_idle(5);
        push_frame(32'h00000005);
        push_idle(5);
        push_frame(32'hC6500002);
        push_idle(60);
        push_frame(32'h46500009);
        push_idle(400);
        while (sq.size() > 0) begin
            tick(sq.pop_front());
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL ignored_wave: got %h want %h", obs, exp_vec()); end
            dn += int'(o_Done);
            hi += int'(o_Step);
        end
        n_cmp++;
        if (dn !== 2) begin n_bad++; $display("FAIL ignored_done: got %0d want 2", dn); end
        n_cmp++;
        if (hi !== 200) begin n_bad++; $display("FAIL ignored_high: got %0d want 200", hi); end
        n_cmp++;
        if ({o_Pin1, o_Pin2} !== 2'b10) begin n_bad++; $display("FAIL ignored_pins: got %b want 10", {o_Pin1, o_Pin2}); end
    endtask

    task automatic test_reset_mid();
        int dn;
        dn = 0;
        push_frame(32'hC6500003);
        push_idle(40);
        while (sq.size() > 0) begin
            tick(sq.pop_front());
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL rstmid_pre: got %h want %h", obs, exp_vec()); end
        end
        n_cmp++;
        if (o_Step !== 1'b1) begin n_bad++; $display("FAIL rstmid_step_high: got %b want 1", o_Step); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 22'h0) begin n_bad++; $display("FAIL rstmid_async: got %h want 000000", obs); end
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL rstmid_release: got %h want %h", obs, exp_vec()); end
        push_frame(32'h46500001);
        push_idle(21 + 100 + 10);
        while (sq.size() > 0) begin
            tick(sq.pop_front());
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL rstmid_post: got %h want %h", obs, exp_vec()); end
            dn += int'(o_Done);
        end
        n_cmp++;
        if (dn !== 1) begin n_bad++; $display("FAIL rstmid_done: got %0d want 1", dn); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 14; f++) begin
            logic [14:0] rpm;
            logic [15:0] stp;
            logic [31:0] w;
            int nb;
            rpm = $urandom_range(0, 4) == 0 ? 15'd0 : 15'($urandom_range(18000, 32767));
            stp = 16'($urandom_range(0, 3));
            w = {1'($urandom_range(0, 1)), rpm, stp};
            nb = $urandom_range(0, 6) == 0 ? $urandom_range(1, 3) : 4;
            for (int i = 0; i < nb; i++) begin
                push_byte(w[8*i +: 8]);
                if (i < 3) push_idle($urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) == 0 ? BT - 1 : BT) : $urandom_range(0, 3));
            end
            push_idle($urandom_range(0, 700));
        end
        push_idle(800);
        while (sq.size() > 0) begin
            tick(sq.pop_front());
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL random_wave: got %h want %h", obs, exp_vec()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_direction();
        test_timeout();
        test_abort();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stepper_cmd_sequencer.md
STEPPER_CMD_SEQUENCER -- requirements
Module: stepper_cmd_sequencer

Interface
REQ-001 Parameter STEP_DIV_NUM, default 1800000, is the dividend; half-step period in clocks = STEP_DIV_NUM / rpm.
REQ-002 Parameter BYTE_TIMEOUT, default 100000, is the maximum idle clocks between bytes of one frame.
REQ-003 i_Clock  input  1  single clock; all logic on its rising edge.
REQ-004 i_Rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_Rx_DV  input  1  one-cycle strobe: i_Rx_Byte valid.
REQ-006 i_Rx_Byte  input  8  received UART byte.
REQ-007 o_Step  output  1  step square wave to driver.
REQ-008 o_Pin1, o_Pin2  output  1 each  direction pair: dir=0 -> 0/1, dir=1 -> 1/0.
REQ-009 o_Busy  output  1  high in S_DIV and S_RUN.
REQ-010 o_Done  output  1  one-cycle pulse when a move completes its step count.
REQ-011 o_Abort  output  1  one-cycle pulse when a stop frame ends a move early.
REQ-012 o_Steps_Left  output  16  remaining full steps of the current move.

Function
REQ-013 Frame = 4 bytes B0..B3; word W = {B3,B2,B1,B0}; dir = W[31], rpm = W[30:16] (15 bits), steps = W[15:0].
REQ-014 Byte index (0..3) advances on each i_Rx_DV and wraps to 0 after B3; the frame is complete on the B3 strobe.
REQ-015 Timeout counter clears on every i_Rx_DV; if index != 0 and counter reaches BYTE_TIMEOUT, index returns to 0 and partial bytes are discarded.
REQ-016 FSM states: S_IDLE, S_DIV, S_RUN.
REQ-017 S_IDLE, complete frame with rpm != 0 and steps != 0 -> latch dir/steps, drive o_Pin1/o_Pin2 next cycle, go S_DIV.
REQ-018 S_IDLE, complete frame with steps == 0 and rpm != 0 -> o_Done pulse next cycle, stay S_IDLE; rpm == 0 frame in S_IDLE -> ignored.
REQ-019 S_DIV: sequential restoring divider, 21 quotient bits MSB first, 1 bit/cycle; exactly 21 cycles, then S_RUN with half-period q = floor(STEP_DIV_NUM / rpm).
REQ-020 Entering S_RUN: o_Step = 1, half-period counter = 0; counter counts 0..q-1, and at q-1 toggles o_Step and reloads 0.
REQ-021 Each high-to-low o_Step toggle decrements o_Steps_Left; when it reaches 0 -> o_Step = 0, o_Done pulses that cycle, go S_IDLE.
REQ-022 Latency: B3 strobe at cycle T -> S_DIV at T+1, first o_Step rise at T+22.
REQ-023 In S_DIV/S_RUN, a complete frame with rpm == 0 (stop) -> o_Step = 0 next cycle, o_Steps_Left = 0, o_Abort pulse, S_IDLE; o_Done not pulsed.
REQ-024 In S_DIV/S_RUN, complete frames with rpm != 0 are discarded; the byte assembler keeps running.
REQ-025 Stop frame in the same cycle as the final step toggle -> the abort path wins (o_Abort, no o_Done).
REQ-026 o_Pin1/o_Pin2 hold the last direction after the move ends; they change only on an accepted frame.

Reset
REQ-027 On i_Rst_n low, immediately and asynchronously: state S_IDLE, byte index 0, timeout 0, o_Step 0, o_Pin1 0, o_Pin2 0, o_Busy 0, o_Done 0, o_Abort 0, o_Steps_Left 0.
REQ-028 Reset mid-move or mid-frame discards all progress; no o_Done/o_Abort pulse on reset release.

Verification
REQ-029 Bytes 03,00,50,C6 (dir=1, rpm=18000, steps=3) -> o_Pin1=1, o_Pin2=0; o_Step rises at T+22; 3 periods of 100 high/100 low; o_Done one pulse; o_Busy low afterward.
REQ-030 Same move but bytes 03,00,50,46 -> o_Pin1=0, o_Pin2=1; identical o_Step timing.
REQ-031 Bytes 03,00 then BYTE_TIMEOUT idle clocks, then 05,00,50,46 -> exactly 5 steps; no stray move from the partial frame.
REQ-032 Start 0x00FF-step move; after 2 steps send 00,00,00,00 -> o_Step low, o_Abort one pulse, o_Steps_Left = 0, no o_Done.
REQ-033 Bytes 00,00,50,46 in S_IDLE -> o_Done pulse only, o_Step stays 0; a non-stop frame during S_RUN -> move continues unchanged.
REQ-034 Assert i_Rst_n low mid-S_RUN with o_Step high -> all outputs 0 immediately; after release a new valid frame runs normally.
